// File: rtl/demux_sel_if.sv
// demux_sel_if
//   Word-in / serial-out bus of demux_sel_sequencer.
//   slave  : sequencer side (takes din/din_valid, drives i/s/s_valid/busy/done/din_ready)
//   master : upstream/driver side, mirror of slave
//   Optional macro DEMUX_SEQ_MASK_EN adds chan_mask (per-channel enable, sampled at accept).
interface demux_sel_if #(
  parameter int NSEL  = 3,
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             i;
  logic [NSEL-1:0]  s;
  logic             s_valid;
  logic             busy;
  logic             done;
`ifdef DEMUX_SEQ_MASK_EN
  logic [WIDTH-1:0] chan_mask;

  modport slave (
    input  din, din_valid, chan_mask,
    output din_ready, i, s, s_valid, busy, done
  );
  modport master (
    output din, din_valid, chan_mask,
    input  din_ready, i, s, s_valid, busy, done
  );
`else
  modport slave (
    input  din, din_valid,
    output din_ready, i, s, s_valid, busy, done
  );
  modport master (
    output din, din_valid,
    input  din_ready, i, s, s_valid, busy, done
  );
`endif
endinterface

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer
//   Accepts one WIDTH-bit word per valid/ready handshake and serialises it onto a
//   1-to-WIDTH demux: bit k goes out on i while s=k, held for DWELL cycles per channel,
//   followed by a one-cycle done pulse.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : demux_sel_if.slave (din, din_valid, din_ready, i, s, s_valid, busy, done
//            and, with DEMUX_SEQ_MASK_EN defined, chan_mask)
//   Optional macro DEMUX_SEQ_MASK_EN: per-channel enable mask captured at accept;
//   disabled channels take zero cycles. Undefined behaves as an all-ones mask.
//
//   state | meaning
//   IDLE  | waiting for a word, din_ready=1
//   SHIFT | presenting channel chan on i/s, dwell counts 0..DWELL-1
//   DONE  | one-cycle end-of-frame pulse, i/s forced to 0
module demux_sel_sequencer #(
  parameter int NSEL  = 3,
  parameter int WIDTH = 8,
  parameter int DWELL = 1
) (
  input logic       clk,
  input logic       rst,
  demux_sel_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] word, word_nxt;
  logic [WIDTH-1:0] mask, mask_nxt, mask_in;
  logic [NSEL-1:0]  chan, chan_nxt;
  logic [7:0]       dwell, dwell_nxt;
  logic             dwell_end;

  logic             i_nxt, s_valid_nxt, busy_nxt, done_nxt;
  logic [NSEL-1:0]  s_nxt;

  // Next-enabled-channel search. search_from is one bit wider than chan so that
  // "after the last channel" is representable and the search simply finds nothing.
  logic [WIDTH-1:0] search_mask;
  logic [NSEL:0]    search_from;
  logic             hit;
  logic [NSEL-1:0]  hit_idx;

`ifdef DEMUX_SEQ_MASK_EN
  assign mask_in = bus.chan_mask;
`else
  assign mask_in = '1;
`endif

  assign dwell_end   = (dwell == 8'(DWELL - 1));
  assign search_mask = (state == IDLE) ? mask_in : mask;
  assign search_from = (state == IDLE) ? '0 : ({1'b0, chan} + (NSEL+1)'(1));

  // Descending scan so the last assignment wins: the lowest enabled index >= search_from.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (search_mask[k] && (k >= int'(search_from))) begin
        hit     = 1'b1;
        hit_idx = NSEL'(k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    mask_nxt  = mask;
    chan_nxt  = chan;
    dwell_nxt = dwell;
    case (state)
      IDLE: begin
        if (bus.din_valid) begin
          word_nxt  = bus.din;
          mask_nxt  = mask_in;
          dwell_nxt = '0;
          if (hit) begin
            state_nxt = SHIFT;
            chan_nxt  = hit_idx;
          end else begin
            state_nxt = DONE;
            chan_nxt  = '0;
          end
        end
      end
      SHIFT: begin
        if (dwell_end) begin
          dwell_nxt = '0;
          if (hit) begin
            chan_nxt = hit_idx;
          end else begin
            chan_nxt  = '0;
            state_nxt = DONE;
          end
        end else begin
          dwell_nxt = dwell + 8'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from next-state values so channel 0 shows up the
    // cycle right after the accepting edge.
    s_valid_nxt = (state_nxt == SHIFT);
    s_nxt       = s_valid_nxt ? chan_nxt : '0;
    i_nxt       = s_valid_nxt & word_nxt[chan_nxt];
    done_nxt    = (state_nxt == DONE);
    busy_nxt    = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word        <= '0;
      mask        <= '0;
      chan        <= '0;
      dwell       <= '0;
      bus.i       <= 1'b0;
      bus.s       <= '0;
      bus.s_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      word        <= word_nxt;
      mask        <= mask_nxt;
      chan        <= chan_nxt;
      dwell       <= dwell_nxt;
      bus.i       <= i_nxt;
      bus.s       <= s_nxt;
      bus.s_valid <= s_valid_nxt;
      bus.busy    <= busy_nxt;
      bus.done    <= done_nxt;
    end
  end

  assign bus.din_ready = (state == IDLE);

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench for demux_sel_sequencer: two instances (DWELL=1 and DWELL=3), table-driven
// frames plus random frames, each compared cycle by cycle against a list of expected
// per-cycle observations built from the frame rules.
module tb_demux_sel_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_sel_if #(.NSEL(3), .WIDTH(8)) b1 ();
  demux_sel_if #(.NSEL(3), .WIDTH(8)) b3 ();

  demux_sel_sequencer #(.NSEL(3), .WIDTH(8), .DWELL(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  demux_sel_sequencer #(.NSEL(3), .WIDTH(8), .DWELL(3)) d3 (.clk(clk), .rst(rst), .bus(b3));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         which;
    logic [7:0] word;
    logic [7:0] mask;
    int         noise;     // 0 quiet, 1 random din_valid while busy, 2 din_valid held high
    int         done_cyc;  // cycle after accept where done must pulse, -1 = not checked
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Observation packed as {din_ready, busy, done, s_valid, s[2:0], i}
  function automatic logic [7:0] obs(input int which);
    if (which == 3) return {b3.din_ready, b3.busy, b3.done, b3.s_valid, b3.s, b3.i};
    return {b1.din_ready, b1.busy, b1.done, b1.s_valid, b1.s, b1.i};
  endfunction

  task automatic drive(input int which, input logic [7:0] d, input logic v, input logic [7:0] m);
    if (which == 3) begin
      b3.din = d;
      b3.din_valid = v;
`ifdef DEMUX_SEQ_MASK_EN
      b3.chan_mask = m;
`endif
    end else begin
      b1.din = d;
      b1.din_valid = v;
`ifdef DEMUX_SEQ_MASK_EN
      b1.chan_mask = m;
`endif
    end
  endtask

  function automatic logic [7:0] mask_eff(input logic [7:0] m);
`ifdef DEMUX_SEQ_MASK_EN
    return m;
`else
    return (m | 8'hFF);
`endif
  endfunction

  // Entered and left at a negedge with the selected instance idle.
  task automatic frame(input int which, input logic [7:0] word, input logic [7:0] mask,
                       input int noise, input int done_cyc, output time t_acc);
    logic [7:0] exp_q[$];
    logic [7:0] m;
    logic [7:0] o;
    int         dw;
    int         seen_done;
    logic       v;
    dw = (which == 3) ? 3 : 1;
    m  = mask_eff(mask);
    for (int k = 0; k < 8; k++)
      if (m[k])
        for (int r = 0; r < dw; r++)
          exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b1, 3'(k), word[k]});
    exp_q.push_back(8'b0110_0000);
    exp_q.push_back(8'b1000_0000);

    check("ready_before_accept", int'(obs(which)), 8'h80);
    drive(which, word, 1'b1, mask);
    seen_done = -1;
    t_acc = 0;
    for (int r = 0; r < exp_q.size(); r++) begin
      @(negedge clk);
      if (r == 0) t_acc = $time;
      o = obs(which);
      if (o[5] && seen_done < 0) seen_done = r + 1;
      check($sformatf("frame_u%0d_w%02h_cyc%0d", which, word, r + 1), int'(o), int'(exp_q[r]));
      v = 1'b0;
      if (exp_q[r][6]) v = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(1)) : 1'b0;
      drive(which, 8'($urandom), v, 8'($urandom));
    end
    if (done_cyc >= 0) check("done_cycle", seen_done, done_cyc);
  endtask

  vec_t vecs[$];
  time  t_acc;
  time  t_prev;
  bit   saw_done;

  initial begin
    drive(1, 8'h00, 1'b0, 8'hFF);
    drive(3, 8'h00, 1'b0, 8'hFF);
    repeat (3) @(negedge clk);
    check("reset_u1", int'(obs(1)), 8'h80);
    check("reset_u3", int'(obs(3)), 8'h80);
    rst = 1'b0;
    @(negedge clk);

    // Abort mid-SHIFT: async clear, then clean idle with no done pulse.
    drive(1, 8'hA5, 1'b1, 8'hFF);
    @(negedge clk);
    drive(1, 8'h00, 1'b0, 8'hFF);
    repeat (3) @(negedge clk);
    check("mid_shift_busy", int'(obs(1)), {1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0});
    #2 rst = 1'b1;
    #1 check("async_reset", int'(obs(1)), 8'h80);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_release", int'(obs(1)), 8'h80);
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (b1.done || b1.busy) saw_done = 1'b1;
    end
    check("no_done_after_abort", int'(saw_done), 0);

    vecs.push_back('{1, 8'hA5, 8'hFF, 0, 9});
    vecs.push_back('{3, 8'h81, 8'hFF, 1, 25});
    vecs.push_back('{1, 8'hFF, 8'hFF, 2, 9});
    vecs.push_back('{1, 8'h00, 8'hFF, 2, 9});
    vecs.push_back('{3, 8'h3C, 8'hFF, 2, 25});
`ifdef DEMUX_SEQ_MASK_EN
    vecs.push_back('{1, 8'hFF, 8'b0010_0100, 1, 3});
    vecs.push_back('{1, 8'hFF, 8'h00, 1, 1});
    vecs.push_back('{3, 8'hFF, 8'b0010_0100, 0, 7});
    vecs.push_back('{1, 8'h5A, 8'h80, 0, 2});
`endif
    t_prev = 0;
    for (int n = 0; n < vecs.size(); n++) begin
      frame(vecs[n].which, vecs[n].word, vecs[n].mask, vecs[n].noise, vecs[n].done_cyc, t_acc);
      if (n == 3) check("back_to_back_period", int'((t_acc - t_prev) / 10), 10);
      t_prev = t_acc;
    end

    for (int n = 0; n < 20; n++) begin
      frame(($urandom_range(1) == 1) ? 3 : 1, 8'($urandom),
            ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom), 1, -1, t_acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
